// File: rtl/ecc_scrub_pkg.sv
// Shared types for the ECC scrubber: FSM states, error classes and the
// per-register classification rule.
package ecc_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SCRUB,
    SETTLE
  } scrub_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_PAR,
    ERR_SBE,
    ERR_DBE
  } err_kind_t;

  // An uncorrectable error masks any correctable flag on the same register.
  function automatic err_kind_t classify_err(input logic dbe, input logic sbe, input logic par);
    if (dbe)      return ERR_DBE;
    else if (sbe) return ERR_SBE;
    else if (par) return ERR_PAR;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/ecc_scrubber_sat_counter.sv
// Saturating event counter; a clear coincident with an event loads 1 so
// the event is not lost.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr)                    cnt_d = inc ? W'(1) : '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (!reset_b) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ecc_scrubber.sv
// Background scrub controller: walks the ecc_reg array one register per cycle,
// rewrites correctable words and logs uncorrectable ones.
module ecc_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int  NUM_REGS     = 100,
  parameter int  NUM_REG_BITS = 8,
  parameter int  CNT_W        = 16,
  localparam int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    scan_en,
  input  logic                    clr,
  input  logic [NUM_REG_BITS-1:0] reg_dout [NUM_REGS],
  input  logic [NUM_REGS-1:0]     single_bit_err,
  input  logic [NUM_REGS-1:0]     double_bit_err,
  input  logic [NUM_REGS-1:0]     parity_bit_err,
  output logic [NUM_REGS-1:0]     scrub_w_en,
  output logic [NUM_REG_BITS-1:0] scrub_w_din,
  output logic [CNT_W-1:0]        sbe_cnt,
  output logic [CNT_W-1:0]        dbe_cnt,
  output logic [IDX_W-1:0]        last_err_idx,
  output logic                    dbe_irq,
  output logic                    sweep_done,
  output logic                    busy
);

  scrub_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_next;
  logic [NUM_REGS-1:0]     w_en_q, w_en_d;
  logic [NUM_REG_BITS-1:0] w_din_q, w_din_d;
  logic [IDX_W-1:0]        last_idx_q, last_idx_d;
  logic                    irq_q, irq_d;
  logic                    done_q, done_d;
  logic                    wrap;
  logic                    sbe_inc, dbe_inc;
  err_kind_t               err_kind;

  assign wrap     = (idx_q == IDX_W'(NUM_REGS - 1));
  assign idx_next = wrap ? '0 : idx_q + 1'b1;
  assign err_kind = classify_err(double_bit_err[idx_q], single_bit_err[idx_q],
                                 parity_bit_err[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    w_en_d     = '0;
    w_din_d    = w_din_q;
    last_idx_d = last_idx_q;
    irq_d      = irq_q;
    done_d     = 1'b0;
    sbe_inc    = 1'b0;
    dbe_inc    = 1'b0;

    case (state_q)
      IDLE: if (scan_en) state_d = SCAN;
      SCAN: begin
        if (!scan_en) begin
          state_d = IDLE;
        end else begin
          case (err_kind)
            ERR_DBE: begin
              dbe_inc    = 1'b1;
              last_idx_d = idx_q;
              irq_d      = 1'b1;
              idx_d      = idx_next;
              done_d     = wrap;
            end
            ERR_SBE, ERR_PAR: begin
              w_din_d       = reg_dout[idx_q];
              w_en_d[idx_q] = 1'b1;
              state_d       = SCRUB;
            end
            default: begin
              idx_d  = idx_next;
              done_d = wrap;
            end
          endcase
        end
      end
      SCRUB: begin
        sbe_inc = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Flags have refreshed through the ecc_reg stage; move on.
        idx_d   = idx_next;
        done_d  = wrap;
        state_d = scan_en ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      irq_d      = dbe_inc;
      last_idx_d = dbe_inc ? idx_q : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      w_en_q     <= '0;
      w_din_q    <= '0;
      last_idx_q <= '0;
      irq_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      w_en_q     <= w_en_d;
      w_din_q    <= w_din_d;
      last_idx_q <= last_idx_d;
      irq_q      <= irq_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_sbe_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (sbe_inc),
    .clr     (clr),
    .cnt     (sbe_cnt)
  );

  sat_counter #(.W(CNT_W)) u_dbe_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (dbe_inc),
    .clr     (clr),
    .cnt     (dbe_cnt)
  );

  assign scrub_w_en   = w_en_q;
  assign scrub_w_din  = w_din_q;
  assign last_err_idx = last_idx_q;
  assign dbe_irq      = irq_q;
  assign sweep_done   = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: sweep timing, repair, DBE logging,
// saturation/clear, pause/resume and asynchronous reset.
module tb_ecc_scrubber;

  localparam int NR = 100;
  localparam int NB = 8;
  localparam int CW = 2;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          scan_en = 1'b0;
  logic          clr = 1'b0;
  logic [NB-1:0] reg_dout [NR];
  logic [NR-1:0] sbe = '0, dbe = '0, par = '0;
  logic [NR-1:0] scrub_w_en;
  logic [NB-1:0] scrub_w_din;
  logic [CW-1:0] sbe_cnt, dbe_cnt;
  logic [IW-1:0] last_err_idx;
  logic          dbe_irq, sweep_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ecc_scrubber #(.NUM_REGS(NR), .NUM_REG_BITS(NB), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .scan_en        (scan_en),
    .clr            (clr),
    .reg_dout       (reg_dout),
    .single_bit_err (sbe),
    .double_bit_err (dbe),
    .parity_bit_err (par),
    .scrub_w_en     (scrub_w_en),
    .scrub_w_din    (scrub_w_din),
    .sbe_cnt        (sbe_cnt),
    .dbe_cnt        (dbe_cnt),
    .last_err_idx   (last_err_idx),
    .dbe_irq        (dbe_irq),
    .sweep_done     (sweep_done),
    .busy           (busy)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset_b = 1'b0;
    scan_en = 1'b0;
    clr     = 1'b0;
    sbe     = '0;
    dbe     = '0;
    par     = '0;
    for (int i = 0; i < NR; i++) reg_dout[i] = NB'(i * 3 + 1);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++; if (scrub_w_en !== '0) begin n_bad++; $display("FAIL reset_w_en: got %h want 0", scrub_w_en); end
    n_cmp++; if (scrub_w_din !== '0) begin n_bad++; $display("FAIL reset_w_din: got %h want 0", scrub_w_din); end
    n_cmp++; if ({sbe_cnt, dbe_cnt, last_err_idx} !== '0) begin n_bad++; $display("FAIL reset_cnt_log: sbe=%0d dbe=%0d idx=%0d want 0", sbe_cnt, dbe_cnt, last_err_idx); end
    n_cmp++; if ({dbe_irq, sweep_done, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: irq/done/busy=%b want 000", {dbe_irq, sweep_done, busy}); end
  endtask

  task automatic test_clean_sweep();
    int first, second, pulses, writes;
    logic cnt_nz;
    first = 0; second = 0; pulses = 0; writes = 0; cnt_nz = 1'b0;
    apply_reset();
    scan_en = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      @(negedge clk);
      if (sweep_done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (scrub_w_en !== '0) writes++;
      if (sbe_cnt !== '0 || dbe_cnt !== '0) cnt_nz = 1'b1;
    end
    n_cmp++; if (first != 101) begin n_bad++; $display("FAIL clean_first_done: got cycle %0d want 101", first); end
    n_cmp++; if (second != 201) begin n_bad++; $display("FAIL clean_second_done: got cycle %0d want 201", second); end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL clean_done_pulses: got %0d want 2", pulses); end
    n_cmp++; if (writes != 0) begin n_bad++; $display("FAIL clean_no_writes: got %0d write cycles want 0", writes); end
    n_cmp++; if (cnt_nz !== 1'b0) begin n_bad++; $display("FAIL clean_counters: saw nonzero counter, want 0"); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy: got %b want 1", busy); end
    scan_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clean_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_sbe_repair();
    logic [NR-1:0] exp37, exp80;
    int first, second, writes;
    exp37 = '0; exp37[37] = 1'b1;
    exp80 = '0; exp80[80] = 1'b1;
    first = 0; second = 0; writes = 0;
    apply_reset();
    sbe[37] = 1'b1; reg_dout[37] = 8'hA5;
    par[80] = 1'b1; reg_dout[80] = 8'h3C;
    scan_en = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      if (scrub_w_en !== '0) writes++;
      if (sweep_done === 1'b1) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (k == 39) begin
        n_cmp++; if (scrub_w_en !== exp37) begin n_bad++; $display("FAIL sbe_w_en: got %h want %h", scrub_w_en, exp37); end
        n_cmp++; if (scrub_w_din !== 8'hA5) begin n_bad++; $display("FAIL sbe_w_din: got %h want a5", scrub_w_din); end
      end
      if (k == 40) begin
        n_cmp++; if (sbe_cnt !== 2'd1) begin n_bad++; $display("FAIL sbe_cnt_one: got %0d want 1", sbe_cnt); end
        sbe[37] = 1'b0;
      end
      if (k == 84) begin
        n_cmp++; if (scrub_w_en !== exp80) begin n_bad++; $display("FAIL par_w_en: got %h want %h", scrub_w_en, exp80); end
        n_cmp++; if (scrub_w_din !== 8'h3C) begin n_bad++; $display("FAIL par_w_din: got %h want 3c", scrub_w_din); end
      end
      if (k == 85) par[80] = 1'b0;
      if (k == 100) begin
        n_cmp++; if (scrub_w_din !== 8'h3C) begin n_bad++; $display("FAIL w_din_hold: got %h want 3c", scrub_w_din); end
      end
    end
    n_cmp++; if (writes != 2) begin n_bad++; $display("FAIL repair_write_cycles: got %0d want 2", writes); end
    n_cmp++; if (first != 105) begin n_bad++; $display("FAIL repair_first_done: got cycle %0d want 105", first); end
    n_cmp++; if (second != 205) begin n_bad++; $display("FAIL repair_second_done: got cycle %0d want 205", second); end
    n_cmp++; if (sbe_cnt !== 2'd2 || dbe_cnt !== 2'd0) begin n_bad++; $display("FAIL repair_counts: sbe=%0d dbe=%0d want 2/0", sbe_cnt, dbe_cnt); end
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dbe_with_sbe();
    int first, writes;
    first = 0; writes = 0;
    apply_reset();
    dbe[5] = 1'b1; sbe[5] = 1'b1; reg_dout[5] = 8'hFF;
    scan_en = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (scrub_w_en !== '0) writes++;
      if (sweep_done === 1'b1 && first == 0) first = k;
      if (k == 6) begin
        n_cmp++; if (dbe_cnt !== 2'd0 || dbe_irq !== 1'b0) begin n_bad++; $display("FAIL dbe_early: cnt=%0d irq=%b want 0/0", dbe_cnt, dbe_irq); end
      end
      if (k == 7) begin
        n_cmp++; if (dbe_cnt !== 2'd1) begin n_bad++; $display("FAIL dbe_cnt: got %0d want 1", dbe_cnt); end
        n_cmp++; if (last_err_idx !== 7'd5) begin n_bad++; $display("FAIL dbe_last_idx: got %0d want 5", last_err_idx); end
        n_cmp++; if (dbe_irq !== 1'b1) begin n_bad++; $display("FAIL dbe_irq: got %b want 1", dbe_irq); end
        n_cmp++; if (sbe_cnt !== 2'd0) begin n_bad++; $display("FAIL dbe_sbe_cnt: got %0d want 0", sbe_cnt); end
      end
    end
    n_cmp++; if (writes != 0) begin n_bad++; $display("FAIL dbe_no_write: got %0d write cycles want 0", writes); end
    n_cmp++; if (first != 101) begin n_bad++; $display("FAIL dbe_sweep_len: done at cycle %0d want 101", first); end
    n_cmp++; if (dbe_cnt !== 2'd1) begin n_bad++; $display("FAIL dbe_cnt_hold: got %0d want 1", dbe_cnt); end
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturation_clear();
    apply_reset();
    for (int i = 0; i < 5; i++) dbe[i] = 1'b1;
    dbe[10] = 1'b1;
    scan_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) begin
        n_cmp++; if (dbe_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_reach: got %0d want 3", dbe_cnt); end
      end
      if (k == 6) begin
        n_cmp++; if (dbe_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %0d want 3", dbe_cnt); end
        n_cmp++; if (last_err_idx !== 7'd4) begin n_bad++; $display("FAIL sat_last_idx: got %0d want 4", last_err_idx); end
      end
      if (k == 11) clr = 1'b1;
      if (k == 12) begin
        clr = 1'b0;
        scan_en = 1'b0;
        n_cmp++; if (dbe_cnt !== 2'd1) begin n_bad++; $display("FAIL clr_inc_cnt: got %0d want 1", dbe_cnt); end
        n_cmp++; if (dbe_irq !== 1'b1) begin n_bad++; $display("FAIL clr_inc_irq: got %b want 1", dbe_irq); end
        n_cmp++; if (last_err_idx !== 7'd10) begin n_bad++; $display("FAIL clr_inc_idx: got %0d want 10", last_err_idx); end
      end
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++; if (dbe_cnt !== 2'd0 || sbe_cnt !== 2'd0) begin n_bad++; $display("FAIL clr_cnts: dbe=%0d sbe=%0d want 0/0", dbe_cnt, sbe_cnt); end
    n_cmp++; if (dbe_irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq: got %b want 0", dbe_irq); end
    n_cmp++; if (last_err_idx !== 7'd0) begin n_bad++; $display("FAIL clr_idx: got %0d want 0", last_err_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy: got %b want 0", busy); end
  endtask

  task automatic test_pause_resume();
    logic [NR-1:0] exp10;
    exp10 = '0; exp10[10] = 1'b1;
    apply_reset();
    sbe[10] = 1'b1; reg_dout[10] = 8'h5A;
    dbe[11] = 1'b1;
    scan_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 12) begin
        n_cmp++; if (scrub_w_en !== exp10 || scrub_w_din !== 8'h5A) begin n_bad++; $display("FAIL pause_write: en=%h din=%h want %h/5a", scrub_w_en, scrub_w_din, exp10); end
        scan_en = 1'b0;
      end
      if (k == 13) begin
        n_cmp++; if (busy !== 1'b1 || scrub_w_en !== '0 || sbe_cnt !== 2'd1) begin n_bad++; $display("FAIL pause_settle: busy=%b en=%h sbe=%0d want 1/0/1", busy, scrub_w_en, sbe_cnt); end
        sbe[10] = 1'b0;
      end
      if (k == 14 || k == 17) begin
        n_cmp++; if (busy !== 1'b0 || dbe_cnt !== 2'd0) begin n_bad++; $display("FAIL pause_idle_c%0d: busy=%b dbe=%0d want 0/0", k, busy, dbe_cnt); end
      end
      if (k == 18) scan_en = 1'b1;
      if (k == 19) begin
        n_cmp++; if (busy !== 1'b1 || dbe_cnt !== 2'd0) begin n_bad++; $display("FAIL resume_start: busy=%b dbe=%0d want 1/0", busy, dbe_cnt); end
      end
      if (k == 20) begin
        n_cmp++; if (dbe_cnt !== 2'd1 || last_err_idx !== 7'd11) begin n_bad++; $display("FAIL resume_idx: dbe=%0d idx=%0d want 1/11", dbe_cnt, last_err_idx); end
      end
    end
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [NR-1:0] exp3;
    exp3 = '0; exp3[3] = 1'b1;
    apply_reset();
    sbe[3] = 1'b1; reg_dout[3] = 8'hC3;
    scan_en = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (scrub_w_en !== exp3) begin n_bad++; $display("FAIL arst_pre_write: got %h want %h", scrub_w_en, exp3); end
    #2 reset_b = 1'b0;
    #1;
    n_cmp++; if (scrub_w_en !== '0 || scrub_w_din !== '0) begin n_bad++; $display("FAIL arst_write_drop: en=%h din=%h want 0/0", scrub_w_en, scrub_w_din); end
    n_cmp++; if ({sbe_cnt, dbe_cnt, last_err_idx, dbe_irq, sweep_done, busy} !== '0) begin n_bad++; $display("FAIL arst_outputs: sbe=%0d dbe=%0d idx=%0d irq/done/busy=%b want all 0", sbe_cnt, dbe_cnt, last_err_idx, {dbe_irq, sweep_done, busy}); end
    sbe = '0;
    @(negedge clk);
    dbe[0] = 1'b1;
    reset_b = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || dbe_cnt !== 2'd0) begin n_bad++; $display("FAIL arst_restart: busy=%b dbe=%0d want 1/0", busy, dbe_cnt); end
    @(negedge clk);
    n_cmp++; if (dbe_cnt !== 2'd1 || dbe_irq !== 1'b1 || last_err_idx !== 7'd0) begin n_bad++; $display("FAIL arst_idx_zero: dbe=%0d irq=%b idx=%0d want 1/1/0", dbe_cnt, dbe_irq, last_err_idx); end
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) reg_dout[i] = '0;
    test_reset();
    test_clean_sweep();
    test_sbe_repair();
    test_dbe_with_sbe();
    test_saturation_clear();
    test_pause_resume();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
